// File: rtl/vend_front_panel.sv
// rtl/vend_front_panel.sv - coin/button input conditioner for the vending machine FSM
// Sync, debounce, one-pulse-per-press, and single-grant arbitration with selection lockout.
module vend_front_panel #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic CLK,
    input  logic rst,
    input  logic raw_ni,
    input  logic raw_di,
    input  logic raw_qu,
    input  logic raw_soda,
    input  logic raw_diet,
    input  logic giveSoda,
    input  logic giveDiet,
    output logic ni,
    output logic di,
    output logic qu,
    output logic soda,
    output logic diet,
    output logic sel_dropped,
    output logic pending_any
);

    localparam int               NCH     = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Channel bit order: 0 ni, 1 di, 2 qu, 3 soda, 4 diet
    localparam logic [NCH-1:0]   SEL_MASK = 5'b11000;

    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   s1_q, s2_q;
    logic [NCH-1:0]   stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [NCH-1:0]   set_d;
    logic [NCH-1:0]   pend_q, pend_d;
    logic [NCH-1:0]   pulse_q, pulse_d;
    logic [NCH-1:0]   drop, elig, grant;
    logic             lock;
    logic             sel_dropped_q, sel_dropped_d;
    logic             pending_any_q, pending_any_d;

    assign raw = {raw_diet, raw_soda, raw_qu, raw_di, raw_ni};

    always_comb begin
        stable_d = stable_q;
        set_d    = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
                set_d[i]    = s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Grants use last edge's pending state, so a bit set this edge waits a cycle.
    always_comb begin
        lock  = giveSoda | giveDiet;
        drop  = lock ? (pend_q & SEL_MASK) : '0;
        elig  = pend_q & ~drop;
        grant = '0;
        if (elig[2])      grant = 5'b00100;
        else if (elig[1]) grant = 5'b00010;
        else if (elig[0]) grant = 5'b00001;
        else if (elig[3]) grant = 5'b01000;
        else if (elig[4]) grant = 5'b10000;
        pend_d        = (pend_q & ~grant & ~drop) | set_d;
        pulse_d       = grant;
        sel_dropped_d = |drop;
        pending_any_d = |pend_d;
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            s1_q          <= '0;
            s2_q          <= '0;
            stable_q      <= '0;
            pend_q        <= '0;
            pulse_q       <= '0;
            sel_dropped_q <= 1'b0;
            pending_any_q <= 1'b0;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else begin
            s1_q          <= raw;
            s2_q          <= s1_q;
            stable_q      <= stable_d;
            pend_q        <= pend_d;
            pulse_q       <= pulse_d;
            sel_dropped_q <= sel_dropped_d;
            pending_any_q <= pending_any_d;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign ni          = pulse_q[0];
    assign di          = pulse_q[1];
    assign qu          = pulse_q[2];
    assign soda        = pulse_q[3];
    assign diet        = pulse_q[4];
    assign sel_dropped = sel_dropped_q;
    assign pending_any = pending_any_q;

endmodule

// File: tb/tb_vend_front_panel.sv
// tb/tb_vend_front_panel.sv - directed self-checking bench for vend_front_panel
module tb_vend_front_panel;

    logic CLK = 1'b0;
    logic rst = 1'b0;
    logic raw_ni = 0, raw_di = 0, raw_qu = 0, raw_soda = 0, raw_diet = 0;
    logic giveSoda = 0, giveDiet = 0;
    logic ni, di, qu, soda, diet, sel_dropped, pending_any;

    int tests_run = 0;
    int tests_failed = 0;
    int ecnt = 0;
    int n_ni, n_di, n_qu, n_soda, n_diet, n_drop, n_multi;
    int ni_at, di_at, qu_at, diet_at, drop_at;
    int start;

    vend_front_panel #(.DEBOUNCE_CYCLES(16), .CNT_W(8)) dut (
        .CLK(CLK), .rst(rst),
        .raw_ni(raw_ni), .raw_di(raw_di), .raw_qu(raw_qu),
        .raw_soda(raw_soda), .raw_diet(raw_diet),
        .giveSoda(giveSoda), .giveDiet(giveDiet),
        .ni(ni), .di(di), .qu(qu), .soda(soda), .diet(diet),
        .sel_dropped(sel_dropped), .pending_any(pending_any)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) ecnt <= ecnt + 1;

    // Pulse monitor: records count and the edge that registered each pulse
    always @(negedge CLK) begin
        if (ni)   begin n_ni++;   ni_at   = ecnt; end
        if (di)   begin n_di++;   di_at   = ecnt; end
        if (qu)   begin n_qu++;   qu_at   = ecnt; end
        if (soda) n_soda++;
        if (diet) begin n_diet++; diet_at = ecnt; end
        if (sel_dropped) begin n_drop++; drop_at = ecnt; end
        if ($countones({ni, di, qu, soda, diet}) > 1) n_multi++;
    end

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic clear_counts();
        n_ni = 0; n_di = 0; n_qu = 0; n_soda = 0; n_diet = 0; n_drop = 0; n_multi = 0;
        ni_at = -1; di_at = -1; qu_at = -1; diet_at = -1; drop_at = -1;
    endtask

    initial begin
        clear_counts();
        wait_cyc(3);
        check("reset_outputs", int'({ni, di, qu, soda, diet, sel_dropped, pending_any}), 0);
        rst = 1'b1;
        wait_cyc(3);

        // Clean press on quarter
        clear_counts();
        raw_qu = 1; start = ecnt;
        wait_cyc(100);
        raw_qu = 0;
        wait_cyc(40);
        check("clean_qu_count", n_qu, 1);
        check("clean_qu_latency", qu_at - start, 19);
        check("clean_other", n_ni + n_di + n_soda + n_diet + n_drop, 0);

        // Glitch filter on dime
        clear_counts();
        raw_di = 1; wait_cyc(10);
        raw_di = 0; wait_cyc(5);
        raw_di = 1; wait_cyc(10);
        raw_di = 0; wait_cyc(30);
        check("glitch_di_none", n_di, 0);
        raw_di = 1; wait_cyc(40);
        raw_di = 0; wait_cyc(40);
        check("glitch_di_one", n_di, 1);

        // Simultaneous coins
        clear_counts();
        raw_ni = 1; raw_di = 1; raw_qu = 1; start = ecnt;
        for (int i = 1; i <= 22; i++) begin
            wait_cyc(1);
            if (i == 17) check("sim_pany_17", int'(pending_any), 0);
            if (i == 18) check("sim_pany_18", int'(pending_any), 1);
            if (i == 19) check("sim_pany_19", int'(pending_any), 1);
            if (i == 20) check("sim_pany_20", int'(pending_any), 1);
            if (i == 21) check("sim_pany_21", int'(pending_any), 0);
        end
        wait_cyc(20);
        raw_ni = 0; raw_di = 0; raw_qu = 0;
        wait_cyc(40);
        check("sim_qu_at", qu_at - start, 19);
        check("sim_di_at", di_at - start, 20);
        check("sim_ni_at", ni_at - start, 21);
        check("sim_counts", n_qu * 100 + n_di * 10 + n_ni, 111);

        // Selection lockout during dispense
        clear_counts();
        giveSoda = 1;
        raw_soda = 1; raw_ni = 1; start = ecnt;
        wait_cyc(40);
        raw_soda = 0; raw_ni = 0;
        wait_cyc(40);
        giveSoda = 0;
        wait_cyc(5);
        check("lock_drop_count", n_drop, 1);
        check("lock_drop_at", drop_at - start, 19);
        check("lock_soda_none", n_soda, 0);
        check("lock_ni_count", n_ni, 1);
        check("lock_ni_at", ni_at - start, 19);

        // Reset in the middle of a debounce
        clear_counts();
        raw_diet = 1;
        wait_cyc(10);
        rst = 0;
        #1;
        check("rst_async_outputs", int'({ni, di, qu, soda, diet, sel_dropped, pending_any}), 0);
        check("rst_no_pulse_before", n_diet, 0);
        wait_cyc(5);
        rst = 1; start = ecnt;
        wait_cyc(40);
        raw_diet = 0;
        wait_cyc(40);
        check("rst_diet_count", n_diet, 1);
        check("rst_diet_at", diet_at - start, 19);

        // Bounce train then settle high
        clear_counts();
        raw_qu = 0;
        for (int i = 0; i < 10; i++) begin
            raw_qu = ~raw_qu;
            wait_cyc(3);
        end
        raw_qu = 1;
        wait_cyc(40);
        raw_qu = 0;
        wait_cyc(40);
        check("bounce_qu_count", n_qu, 1);
        check("bounce_other", n_ni + n_di + n_soda + n_diet + n_drop, 0);

        check("never_multi_grant", n_multi, 0);
        check("final_pending_any", int'(pending_any), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vend_front_panel.md
Name: vend_front_panel

Overview:
- Input conditioner between the raw coin-slot/button switches and the vending machine FSM; drives the FSM's ni, di, qu, soda and diet inputs.
- Per input: synchronises the asynchronous switch, debounces it, and converts each debounced press into exactly one single-cycle pulse.
- Arbitrates so that at most one pulse is asserted per clock.
- Takes the FSM's giveSoda/giveDiet back as feedback so selections cannot be issued while a dispense is in progress.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised input must hold a new level before it is accepted; legal range 4..255.
- CNT_W, 8, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- CLK  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- raw_ni, raw_di, raw_qu  input  1 each  raw nickel/dime/quarter coin switches, asynchronous, active-high.
- raw_soda, raw_diet  input  1 each  raw selection buttons, asynchronous, active-high.
- giveSoda, giveDiet  input  1 each  dispense indicators fed back from the vending machine.
- ni, di, qu, soda, diet  output  1 each  registered single-cycle pulses to the vending machine.
- sel_dropped  output  1  registered one-cycle pulse: a selection was discarded because a dispense was active.
- pending_any  output  1  registered; high while any pending bit is set.

Behaviour:
- Reset (rst=0, asynchronous): all sync flops, stable levels, counters, pending bits and outputs are forced to 0. Takes effect immediately, mid-debounce or mid-arbitration.
- Synchroniser: two flops per input (s1, s2). Only s2 is used downstream.
- Debounce, per channel, with registers stable and cnt:
  - If s2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A level change shorter than DEBOUNCE_CYCLES cycles at s2 is ignored entirely.
  - Release (1->0) is debounced identically but produces no pulse.
- Pending set:
  - On the edge where stable goes 0->1, the channel's pending bit is set.
  - A held button yields exactly one pulse per press.
- Arbiter: each edge, grants the highest-priority set pending bit, in order qu > di > ni > soda > diet.
  - The granted bit is cleared and its output is registered high for exactly one cycle.
  - All other outputs are 0 in that cycle.
  - Non-granted pending bits stay set and are granted on later cycles.
- Selection lockout: while giveSoda|giveDiet is high, any set soda/diet pending bit is cleared without a pulse, and sel_dropped pulses one cycle.
  - Coin pending bits are never dropped; they continue to be granted during a dispense.
- Simultaneous events: a pending bit set and granted in the same cycle cannot occur, because a grant always uses the pending state from the previous edge.
- Latency: a clean raw 0->1 transition held steady is first sampled at edge 1, and the pulse is high during the cycle after edge DEBOUNCE_CYCLES+3, provided that channel wins arbitration. Each lost arbitration adds one cycle.
- Width rules: cnt saturates at DEBOUNCE_CYCLES-1 by construction and never wraps.
- Re-press of the same channel before its pending bit is granted cannot occur: a re-press needs at least 2*DEBOUNCE_CYCLES cycles, and the maximum wait for a grant is 4 cycles.
- Reset release with a button already held: stable=0 and s2=1, so the press debounces fresh and yields exactly one pulse.

Test Plan:
- Clean press, DEBOUNCE_CYCLES=16: raw_qu held high from an edge for 100 cycles -> qu high for exactly one cycle, 19 edges after the first sampling edge; no further pulses; no pulse on release.
- Glitch filter: raw_di high for 10 cycles, low 5, high 10 -> no di pulse. Then high for 40 cycles -> exactly one di pulse.
- Simultaneous coins: raw_ni, raw_di and raw_qu rise on the same edge -> qu, di, ni pulse on three consecutive cycles in that order; pending_any high for the preceding 3 cycles, then low.
- Lockout: giveSoda held high while raw_soda and raw_ni are pressed together -> sel_dropped pulses once, soda never pulses, ni pulses once.
- Reset mid-debounce: raw_diet high; rst driven low at cnt=8, released 5 cycles later with raw_diet still high -> no pulse before reset; exactly one diet pulse 19 edges after release.
- Bounce train: raw_qu toggles every 3 cycles for 30 cycles, then settles high -> exactly one qu pulse; all other outputs stay 0 throughout.
